dcounter_mod: RTL and testbench

- Parametrised synchronous up/down modulo counter cell for the LTspice digital cell set.
- Successor to the single-bit DFF cells: N-bit state, selectable wrap or saturate mode, parallel load, terminal-count flag and registered overflow pulse.
- Used as the generic counter primitive in synthesised mixed-signal control logic: dividers, timers and sequencer step counters.

---
 rtl/dcounter_mod.sv | 90 +++++++++
 tb/tb_dcounter_mod.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcounter_mod.sv
// Parametrised up/down modulo counter with wrap/saturate, load, TC and OV.
// Define DCELLS_CNT_GRAY_EN to add the Gray-coded state output G.
module dcounter_mod #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             C,
    input  logic             RN,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC,
    output logic             OV
`ifdef DCELLS_CNT_GRAY_EN
    ,
    output logic [WIDTH-1:0] G
`endif
);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
        RESET_VAL >= MODULUS) begin : g_param_check
        $error("dcounter_mod: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    // One extra bit keeps MODULUS = 2^WIDTH representable for the load clamp.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ov_q, ov_d;
    logic             at_max, at_zero, d_in_range;

    assign at_max     = (count_q == MAX_Q);
    assign at_zero    = (count_q == '0);
    assign d_in_range = ({1'b0, D} < MOD_W);

    always_comb begin
        // NOTE: defaults first so every path assigns count_d/ov_d and no latch is inferred.
        count_d = count_q;
        ov_d    = 1'b0;
        if (LD) begin
            count_d = d_in_range ? D : MAX_Q;
        end else if (EN) begin
            if (UP) begin
                if (at_max) begin
                    ov_d    = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : '0;
                end else begin
                    count_d = count_q + ONE_Q;
                end
            end else begin
                if (at_zero) begin
                    ov_d    = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : MAX_Q;
                end else begin
                    count_d = count_q - ONE_Q;
                end
            end
        end
    end

    // NOTE: non-blocking assignments for state; reset is asynchronous and acts without C.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            count_q <= RST_Q;
            ov_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ov_q    <= ov_d;
        end
    end

    assign Q  = count_q;
    assign QN = ~count_q;
    assign OV = ov_q;
    // Zero-latency so a downstream stage can use TC directly as its EN.
    assign TC = EN & ~LD & ((UP & at_max) | (~UP & at_zero));

`ifdef DCELLS_CNT_GRAY_EN
    assign G = count_q ^ (count_q >> 1);
`endif

endmodule

// File: tb/tb_dcounter_mod.sv
// Randomised bench for dcounter_mod against an integer reference model,
// plus directed reset, boundary, clamp, chaining and (optional) Gray checks.
module tb_dcounter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rn, en, up, ld, chain_en;
    logic [3:0] d;

    // Instances 0..2 are 4-bit, instance 3 is the 1-bit toggle cell.
    logic [2:0][3:0] q_p, qn_p;
    logic            q_t, qn_t;
    logic [3:0]      tc_v, ov_v;
    logic [3:0]      cq1, cqn1, cq2, cqn2;
    logic            ctc1, ctc2, cov1, cov2;
`ifdef DCELLS_CNT_GRAY_EN
    logic [2:0][3:0] g_p;
    logic            g_t;
    logic [3:0]      cg1, cg2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    int mod_m[4] = '{10, 10, 16, 2};
    int sat_m[4] = '{0, 1, 0, 0};
    int rst_m[4] = '{0, 3, 0, 0};
    int mq[4];
    int mov[4];

    dcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_wrap (
        .C(clk), .RN(rn), .EN(en), .UP(up), .LD(ld), .D(d),
        .Q(q_p[0]), .QN(qn_p[0]), .TC(tc_v[0]), .OV(ov_v[0])
`ifdef DCELLS_CNT_GRAY_EN
        , .G(g_p[0])
`endif
    );

    dcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(3)) u_sat (
        .C(clk), .RN(rn), .EN(en), .UP(up), .LD(ld), .D(d),
        .Q(q_p[1]), .QN(qn_p[1]), .TC(tc_v[1]), .OV(ov_v[1])
`ifdef DCELLS_CNT_GRAY_EN
        , .G(g_p[1])
`endif
    );

    dcounter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(0)) u_full (
        .C(clk), .RN(rn), .EN(en), .UP(up), .LD(ld), .D(d),
        .Q(q_p[2]), .QN(qn_p[2]), .TC(tc_v[2]), .OV(ov_v[2])
`ifdef DCELLS_CNT_GRAY_EN
        , .G(g_p[2])
`endif
    );

    dcounter_mod #(.WIDTH(1), .MODULUS(2), .SATURATE(0), .RESET_VAL(0)) u_tff (
        .C(clk), .RN(rn), .EN(en), .UP(up), .LD(ld), .D(d[0]),
        .Q(q_t), .QN(qn_t), .TC(tc_v[3]), .OV(ov_v[3])
`ifdef DCELLS_CNT_GRAY_EN
        , .G(g_t)
`endif
    );

    dcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_chain1 (
        .C(clk), .RN(rn), .EN(chain_en), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .Q(cq1), .QN(cqn1), .TC(ctc1), .OV(cov1)
`ifdef DCELLS_CNT_GRAY_EN
        , .G(cg1)
`endif
    );

    dcounter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0)) u_chain2 (
        .C(clk), .RN(rn), .EN(ctc1), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .Q(cq2), .QN(cqn2), .TC(ctc2), .OV(cov2)
`ifdef DCELLS_CNT_GRAY_EN
        , .G(cg2)
`endif
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned obs_q(input int i);
        return (i == 3) ? int'(q_t) : int'(q_p[i]);
    endfunction

    function automatic int unsigned obs_qn(input int i);
        return (i == 3) ? int'(qn_t) : int'(qn_p[i]);
    endfunction

`ifdef DCELLS_CNT_GRAY_EN
    function automatic int unsigned obs_g(input int i);
        return (i == 3) ? int'(g_t) : int'(g_p[i]);
    endfunction
`endif

    function automatic int exp_tc(input int i);
        if (!en || ld) return 0;
        if (up)  return (mq[i] == mod_m[i] - 1) ? 1 : 0;
        return (mq[i] == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i]  = rst_m[i];
            mov[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            int dv;
            dv = (i == 3) ? int'(d[0]) : int'(d);
            mov[i] = 0;
            if (ld) begin
                mq[i] = (dv < mod_m[i]) ? dv : mod_m[i] - 1;
            end else if (en && up) begin
                if (mq[i] == mod_m[i] - 1) begin
                    mov[i] = 1;
                    if (sat_m[i] == 0) mq[i] = 0;
                end else begin
                    mq[i] = mq[i] + 1;
                end
            end else if (en) begin
                if (mq[i] == 0) begin
                    mov[i] = 1;
                    if (sat_m[i] == 0) mq[i] = mod_m[i] - 1;
                end else begin
                    mq[i] = mq[i] - 1;
                end
            end
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            int mask;
            mask = (i == 3) ? 1 : 15;
            check($sformatf("q[%0d]", i), obs_q(i), mq[i]);
            check($sformatf("qn[%0d]", i), obs_qn(i), mask ^ mq[i]);
            check($sformatf("ov[%0d]", i), int'(ov_v[i]), mov[i]);
`ifdef DCELLS_CNT_GRAY_EN
            check($sformatf("g[%0d]", i), obs_g(i), mq[i] ^ (mq[i] >> 1));
`endif
        end
    endtask

    task automatic check_tc();
        for (int i = 0; i < 4; i++)
            check($sformatf("tc[%0d]", i), int'(tc_v[i]), exp_tc(i));
    endtask

    // Drive on the falling edge, check TC, then check registered state after the rising edge.
    task automatic cycle(input logic e, input logic u, input logic l, input logic [3:0] dv);
        @(negedge clk);
        en = e; up = u; ld = l; d = dv;
        #1 check_tc();
        @(posedge clk);
        model_edge();
        #1 check_state();
    endtask

    task automatic async_reset();
        en = 1'b0; ld = 1'b0; up = 1'b0;
        #2 rn = 1'b0;
        model_reset();
        #1 check_state();
        #3 rn = 1'b1;
    endtask

    initial begin
        int ov_count;
        rn = 1'b0; en = 1'b0; up = 1'b0; ld = 1'b0; d = '0; chain_en = 1'b0;
        model_reset();
        #7 check_state();
        #5 rn = 1'b1;

        // Load 7, count to 8, then reset asynchronously between clock edges.
        cycle(1'b0, 1'b0, 1'b1, 4'd7);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        async_reset();
        cycle(1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);

        // Up wrap from 8.
        cycle(1'b0, 1'b0, 1'b1, 4'd8);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'd0);

        // Down toward zero: saturating instance pushes against the boundary.
        cycle(1'b0, 1'b0, 1'b1, 4'd1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'd0);

        // Load priority over EN, clamp, plain load.
        cycle(1'b1, 1'b1, 1'b1, 4'hC);
        cycle(1'b0, 1'b0, 1'b1, 4'd3);

        // Full-range instance boundaries (MODULUS = 2^WIDTH).
        cycle(1'b0, 1'b0, 1'b1, 4'd15);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);

        repeat (400) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom % 2),
                  ($urandom_range(0, 7) == 0), 4'($urandom % 16));
        end

        // Chained decade counters: 100 clocks from reset.
        @(negedge clk);
        en = 1'b0; ld = 1'b0;
        @(posedge clk);
        model_edge();
        #1 async_reset();
        check("chain1 reset", int'(cq1), 0);
        check("chain2 reset", int'(cq2), 0);
        chain_en = 1'b1;
        ov_count = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            check("chain1 q", int'(cq1), k % 10);
            check("chain2 q", int'(cq2), (k / 10) % 10);
            if (cov2) ov_count++;
            if (k == 100) check("chain2 ov at 100", int'(cov2), 1);
        end
        check("chain2 ov pulses", ov_count, 1);
        chain_en = 1'b0;

`ifdef DCELLS_CNT_GRAY_EN
        cycle(1'b0, 1'b0, 1'b1, 4'd0);
        for (int s = 0; s < 16; s++) begin
            logic [3:0] prev_g;
            prev_g = g_p[2];
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
            check("gray one-bit step", $countones(g_p[2] ^ prev_g), 1);
            if (mq[2] == 15) check("gray at 15", int'(g_p[2]), 8);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
